// File: rtl/sram_arbiter_if.sv
// Port bundle for the shared SRAM arbiter: two client ports plus SRAM pins.
// The slave view belongs to the arbiter; the master view to its environment.
interface sram_arbiter_if;
  logic        p0_req;
  logic [17:0] p0_addr;
  logic [31:0] p0_wd;
  logic        p0_ack;
  logic        p1_req;
  logic [17:0] p1_addr;
  logic [31:0] p1_rd;
  logic        p1_ack;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [17:0] sram_addr;
  logic [31:0] sram_wd;
  logic        sram_wd_en;
  logic [31:0] sram_rd;
  logic        busy;

  modport slave (
    input  p0_req, p0_addr, p0_wd,
    input  p1_req, p1_addr, sram_rd,
    output p0_ack, p1_rd, p1_ack,
    output sram_ce_n, sram_oe_n, sram_we_n,
    output sram_addr, sram_wd, sram_wd_en,
    output busy
  );

  modport master (
    output p0_req, p0_addr, p0_wd,
    output p1_req, p1_addr, sram_rd,
    input  p0_ack, p1_rd, p1_ack,
    input  sram_ce_n, sram_oe_n, sram_we_n,
    input  sram_addr, sram_wd, sram_wd_en,
    input  busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter and strobe sequencer for the shared async SRAM pair.
// Port 0 writes, port 1 reads; every output is a flop fed from next state.
module sram_arbiter #(
  parameter int WE_CYCLES = 2,
  parameter int RD_CYCLES = 3
) (
  input logic           clk,
  input logic           reset,
  sram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RD_ACCESS,
    RD_DONE
  } state_t;

  localparam logic [3:0] WE_LOAD = 4'(WE_CYCLES - 1);
  localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);

  state_t      state;
  state_t      state_d;
  logic [3:0]  cnt;
  logic [3:0]  cnt_d;
  logic        last;
  logic        last_d;
  logic        gnt0;
  logic        gnt1;
  logic        ce_n_d;
  logic        oe_n_d;
  logic        we_n_d;
  logic        wd_en_d;
  logic        ack0_d;
  logic        ack1_d;
  logic [17:0] addr_d;
  logic [31:0] wd_d;
  logic [31:0] rd_d;

  // On a tie the port that did not win last time is granted.
  assign gnt0 = bus.p0_req & (~bus.p1_req | last);
  assign gnt1 = bus.p1_req & (~bus.p0_req | ~last);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    last_d  = last;
    addr_d  = bus.sram_addr;
    wd_d    = bus.sram_wd;
    rd_d    = bus.p1_rd;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          gnt0: begin
            state_d = WR_SETUP;
            addr_d  = bus.p0_addr;
            wd_d    = bus.p0_wd;
            last_d  = 1'b0;
          end
          gnt1: begin
            state_d = RD_ACCESS;
            cnt_d   = RD_LOAD;
            addr_d  = bus.p1_addr;
            last_d  = 1'b1;
          end
          default: ;
        endcase
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = WE_LOAD;
      end
      WR_PULSE: begin
        if (cnt == 4'd0) state_d = WR_HOLD;
        else             cnt_d   = cnt - 4'd1;
      end
      WR_HOLD: state_d = IDLE;
      RD_ACCESS: begin
        if (cnt == 4'd0) begin
          state_d = RD_DONE;
          rd_d    = bus.sram_rd;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    wd_en_d = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    // Strobes decode the state being entered so they are registered.
    unique case (state_d)
      WR_SETUP: begin
        ce_n_d  = 1'b0;
        wd_en_d = 1'b1;
      end
      WR_PULSE: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        wd_en_d = 1'b1;
      end
      WR_HOLD: begin
        ce_n_d  = 1'b0;
        wd_en_d = 1'b1;
        ack0_d  = 1'b1;
      end
      RD_ACCESS: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      RD_DONE: begin
        ce_n_d = 1'b0;
        ack1_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      last           <= 1'b1;
      bus.sram_ce_n  <= 1'b1;
      bus.sram_oe_n  <= 1'b1;
      bus.sram_we_n  <= 1'b1;
      bus.sram_wd_en <= 1'b0;
      bus.sram_addr  <= 18'd0;
      bus.sram_wd    <= 32'd0;
      bus.p1_rd      <= 32'd0;
      bus.p0_ack     <= 1'b0;
      bus.p1_ack     <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      last           <= last_d;
      bus.sram_ce_n  <= ce_n_d;
      bus.sram_oe_n  <= oe_n_d;
      bus.sram_we_n  <= we_n_d;
      bus.sram_wd_en <= wd_en_d;
      bus.sram_addr  <= addr_d;
      bus.sram_wd    <= wd_d;
      bus.p1_rd      <= rd_d;
      bus.p0_ack     <= ack0_d;
      bus.p1_ack     <= ack1_d;
      bus.busy       <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: cycle-numbered vectors with fixed
// expectations, sampled on the falling edge.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic        rd_const_en = 1'b0;
  logic [31:0] rd_const = 32'd0;

  sram_arbiter_if ifc ();

  sram_arbiter #(
    .WE_CYCLES(2),
    .RD_CYCLES(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  always #5 clk = ~clk;

  // SRAM model: constant word or an address-derived pattern.
  assign ifc.sram_rd = rd_const_en ? rd_const
                     : ({14'd0, ifc.sram_addr} ^ 32'hA500_0000);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_ce"},   32'(ifc.sram_ce_n), 32'd1);
    chk({tag, "_oe"},   32'(ifc.sram_oe_n), 32'd1);
    chk({tag, "_we"},   32'(ifc.sram_we_n), 32'd1);
    chk({tag, "_addr"}, 32'(ifc.sram_addr), 32'd0);
    chk({tag, "_wd"},   ifc.sram_wd,        32'd0);
    chk({tag, "_wden"}, 32'(ifc.sram_wd_en), 32'd0);
    chk({tag, "_ack0"}, 32'(ifc.p0_ack),    32'd0);
    chk({tag, "_ack1"}, 32'(ifc.p1_ack),    32'd0);
    chk({tag, "_rd"},   ifc.p1_rd,          32'd0);
    chk({tag, "_busy"}, 32'(ifc.busy),      32'd0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    ifc.p0_req  = 1'b0;
    ifc.p0_addr = 18'd0;
    ifc.p0_wd   = 32'd0;
    ifc.p1_req  = 1'b0;
    ifc.p1_addr = 18'd0;

    do_reset(3);
    @(negedge clk);
    chk_rst("rst");
    tick();

    // single write
    ifc.p0_req  = 1'b1;
    ifc.p0_addr = 18'h00010;
    ifc.p0_wd   = 32'hDEADBEEF;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("wr_we", 32'(ifc.sram_we_n), 32'(!(k == 2 || k == 3)));
      chk("wr_ack", 32'(ifc.p0_ack), 32'(k == 4));
      chk("wr_wden", 32'(ifc.sram_wd_en), 32'(k >= 1 && k <= 4));
      chk("wr_oe", 32'(ifc.sram_oe_n), 32'd1);
      if (k >= 1 && k <= 4) begin
        chk("wr_addr", 32'(ifc.sram_addr), 32'h00010);
        chk("wr_wd", ifc.sram_wd, 32'hDEADBEEF);
        chk("wr_ce", 32'(ifc.sram_ce_n), 32'd0);
      end
      chk("wr_busy", 32'(ifc.busy), 32'(k >= 1 && k <= 4));
      tick();
      if (k == 4) ifc.p0_req = 1'b0;
    end
    repeat (2) tick();

    // single read
    rd_const_en = 1'b1;
    rd_const    = 32'h12345678;
    ifc.p1_req  = 1'b1;
    ifc.p1_addr = 18'h3FFFF;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("rd_oe", 32'(ifc.sram_oe_n), 32'(!(k >= 1 && k <= 3)));
      chk("rd_wden", 32'(ifc.sram_wd_en), 32'd0);
      chk("rd_ack", 32'(ifc.p1_ack), 32'(k == 4));
      if (k >= 1 && k <= 4)
        chk("rd_addr", 32'(ifc.sram_addr), 32'h3FFFF);
      if (k >= 4)
        chk("rd_data", ifc.p1_rd, 32'h12345678);
      tick();
      if (k == 4) ifc.p1_req = 1'b0;
    end
    rd_const_en = 1'b0;
    repeat (2) tick();

    // both ports held from reset
    reset       = 1'b1;
    ifc.p0_req  = 1'b1;
    ifc.p0_addr = 18'h00055;
    ifc.p0_wd   = 32'h0BADF00D;
    ifc.p1_req  = 1'b1;
    ifc.p1_addr = 18'h00123;
    do_reset(2);
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      chk("rr_ack0", 32'(ifc.p0_ack), 32'(k == 4 || k == 14));
      chk("rr_ack1", 32'(ifc.p1_ack), 32'(k == 9 || k == 19));
      chk("rr_busy", 32'(ifc.busy), 32'(k % 5 != 0));
      chk("rr_ovl", 32'(!ifc.sram_oe_n && ifc.sram_wd_en), 32'd0);
      if (k == 9)
        chk("rr_rd", ifc.p1_rd, 32'hA5000123);
      if (k == 2)
        chk("rr_waddr", 32'(ifc.sram_addr), 32'h00055);
      tick();
      if (k == 19) begin
        ifc.p0_req = 1'b0;
        ifc.p1_req = 1'b0;
      end
    end
    repeat (2) tick();

    // three back-to-back writes
    ifc.p0_req  = 1'b1;
    ifc.p0_addr = 18'h01234;
    ifc.p0_wd   = 32'h55AA55AA;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("b2b_ack", 32'(ifc.p0_ack), 32'(k == 4 || k == 9 || k == 14));
      tick();
      if (k == 14) ifc.p0_req = 1'b0;
    end
    repeat (2) tick();

    // reset in the first WR_PULSE cycle
    ifc.p0_req  = 1'b1;
    ifc.p0_addr = 18'h00777;
    ifc.p0_wd   = 32'hCAFEF00D;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 3) chk_rst("mid");
      chk("mid_we", 32'(ifc.sram_we_n), 32'(!(k == 2 || k == 5 || k == 6)));
      chk("mid_ack", 32'(ifc.p0_ack), 32'(k == 7));
      tick();
      if (k == 1) reset = 1'b1;
      if (k == 2) reset = 1'b0;
      if (k == 7) ifc.p0_req = 1'b0;
    end
    repeat (2) tick();

    // request dropped and address changed after grant
    ifc.p1_req  = 1'b1;
    ifc.p1_addr = 18'h2AAAA;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("drop_ack", 32'(ifc.p1_ack), 32'(k == 4));
      chk("drop_oe", 32'(ifc.sram_oe_n), 32'(!(k >= 1 && k <= 3)));
      if (k >= 1 && k <= 4)
        chk("drop_addr", 32'(ifc.sram_addr), 32'h2AAAA);
      if (k == 4)
        chk("drop_rd", ifc.p1_rd, 32'hA502AAAA);
      tick();
      if (k == 0) begin
        ifc.p1_req  = 1'b0;
        ifc.p1_addr = 18'd0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
